// File: rtl/alu_issue_unit.sv
// alu_issue_unit: two-state issue FSM feeding an external ALU from a 4-entry register file
module alu_issue_unit #(
    parameter int WIDTH = 4,
    parameter int NREG  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [1:0]       in_rd,
    input  logic [1:0]       in_rs1,
    input  logic [1:0]       in_rs2,
    input  logic             ld_en,
    input  logic [1:0]       ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_c,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [7:0]       icount,
    input  logic [1:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);
    typedef enum logic {IDLE, EXEC} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];
    logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, result_q, result_d;
    logic [3:0] alu_sel_q, alu_sel_d;
    logic [1:0] rd_q, rd_d;
    logic done_q, done_d, zero_q, zero_d;
    logic [7:0] icount_q, icount_d;
    always_comb begin
        state_d   = state_q;
        regs_d    = regs_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_sel_d = alu_sel_q;
        rd_d      = rd_q;
        result_d  = result_q;
        zero_d    = zero_q;
        icount_d  = icount_q;
        done_d    = 1'b0;
        if (ld_en) regs_d[ld_addr] = ld_data;
        if (state_q == IDLE) begin
            if (in_valid) begin
                alu_a_d   = regs_q[in_rs1];
                alu_b_d   = regs_q[in_rs2];
                alu_sel_d = in_op;
                rd_d      = in_rd;
                state_d   = EXEC;
            end
        end else begin
            // writeback after the load so it wins on an address collision
            regs_d[rd_q] = alu_c;
            result_d     = alu_c;
            zero_d       = (alu_c == '0);
            icount_d     = icount_q + 8'd1;
            done_d       = 1'b1;
            state_d      = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            regs_q    <= '{default: '0};
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= '0;
            rd_q      <= '0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            icount_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            regs_q    <= regs_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_sel_q <= alu_sel_d;
            rd_q      <= rd_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            icount_q  <= icount_d;
            done_q    <= done_d;
        end
    end
    assign in_ready = (state_q == IDLE);
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_sel  = alu_sel_q;
    assign done     = done_q;
    assign result   = result_q;
    assign zero     = zero_q;
    assign icount   = icount_q;
    assign dbg_data = regs_q[dbg_addr];
endmodule

// File: tb/tb_alu_issue_unit.sv
// tb_alu_issue_unit: directed and random stimulus checked against a cycle-level reference model
module tb_alu_issue_unit;
    logic clk = 1'b0;
    logic rst_n, in_valid, in_ready, ld_en, done, zero;
    logic [3:0] in_op, ld_data, alu_a, alu_b, alu_sel, alu_c, result, dbg_data;
    logic [1:0] in_rd, in_rs1, in_rs2, ld_addr, dbg_addr;
    logic [7:0] icount;
    int checks = 0;
    int errors = 0;

    logic [3:0] mregs [4];
    logic [3:0] ma, mb, msel, mresult;
    logic [1:0] mrd;
    logic mbusy, mdone, mzero;
    logic [7:0] micount;

    alu_issue_unit #(.WIDTH(4), .NREG(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_c(alu_c),
        .done(done), .result(result), .zero(zero), .icount(icount),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // stand-in for the downstream ALU; op 12 always yields 0
    function automatic logic [3:0] alu_fn(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd12:   return 4'd0;
            default: return a + b + op;
        endcase
    endfunction

    always_comb alu_c = alu_fn(alu_sel, alu_a, alu_b);

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model(input logic v, input logic [3:0] op, input logic [1:0] rd, rs1, rs2,
                         input logic le, input logic [1:0] la, input logic [3:0] ld, input logic rn);
        logic [3:0] nregs [4];
        logic [3:0] c;
        if (!rn) begin
            foreach (mregs[i]) mregs[i] = 4'd0;
            {ma, mb, msel, mrd, mresult, micount} = '0;
            {mbusy, mdone} = 2'b00;
            mzero = 1'b1;
            return;
        end
        nregs = mregs;
        if (le) nregs[la] = ld;
        mdone = 1'b0;
        if (mbusy) begin
            c = alu_fn(msel, ma, mb);
            nregs[mrd] = c;
            mresult = c;
            mzero = (c == 4'd0);
            micount = micount + 8'd1;
            mdone = 1'b1;
            mbusy = 1'b0;
        end else if (v) begin
            ma = mregs[rs1];
            mb = mregs[rs2];
            msel = op;
            mrd = rd;
            mbusy = 1'b1;
        end
        mregs = nregs;
    endtask

    task automatic step(input logic v, input logic [3:0] op, input logic [1:0] rd, rs1, rs2,
                        input logic le, input logic [1:0] la, input logic [3:0] ld, input logic rn);
        {in_valid, in_op, in_rd, in_rs1, in_rs2} = {v, op, rd, rs1, rs2};
        {ld_en, ld_addr, ld_data, rst_n} = {le, la, ld, rn};
        model(v, op, rd, rs1, rs2, le, la, ld, rn);
        @(posedge clk);
        #1;
        chk("in_ready", {7'd0, in_ready}, {7'd0, !mbusy});
        chk("done", {7'd0, done}, {7'd0, mdone});
        chk("zero", {7'd0, zero}, {7'd0, mzero});
        chk("result", {4'd0, result}, {4'd0, mresult});
        chk("icount", icount, micount);
        chk("alu_a", {4'd0, alu_a}, {4'd0, ma});
        chk("alu_b", {4'd0, alu_b}, {4'd0, mb});
        chk("alu_sel", {4'd0, alu_sel}, {4'd0, msel});
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            chk("dbg_data", {4'd0, dbg_data}, {4'd0, mregs[i]});
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask
    task automatic load(input logic [1:0] a, input logic [3:0] d);
        step(0, 0, 0, 0, 0, 1, a, d, 1);
    endtask
    task automatic issue(input logic [3:0] op, input logic [1:0] rd, rs1, rs2);
        step(1, op, rd, rs1, rs2, 0, 0, 0, 1);
    endtask
    task automatic reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        dbg_addr = 2'd0;
        reset();
        reset();
        // add
        load(0, 4'd3);
        load(1, 4'd5);
        issue(0, 2, 0, 1);
        chk("add_a", {4'd0, alu_a}, 8'd3);
        chk("add_b", {4'd0, alu_b}, 8'd5);
        chk("add_ready", {7'd0, in_ready}, 8'd0);
        idle();
        chk("add_done", {7'd0, done}, 8'd1);
        chk("add_result", {4'd0, result}, 8'd8);
        chk("add_icount", icount, 8'd1);
        idle();
        chk("done_once", {7'd0, done}, 8'd0);
        // self-overwrite
        issue(1, 1, 1, 1);
        idle();
        chk("self_zero", {7'd0, zero}, 8'd1);
        dbg_addr = 2'd1;
        #1;
        chk("self_r1", {4'd0, dbg_data}, 8'd0);
        // operand read vs load at the handshake edge
        load(1, 4'd5);
        step(1, 0, 3, 1, 1, 1, 1, 4'd9, 1);
        chk("opnd_preload", {4'd0, alu_a}, 8'd5);
        idle();
        // back-to-back with in_valid held
        repeat (6) step(1, 4'($urandom_range(0, 15)), 2'($urandom), 2'($urandom), 2'($urandom), 0, 0, 0, 1);
        idle();
        // writeback vs load collision
        load(0, 4'd3);
        load(1, 4'd5);
        issue(0, 2, 0, 1);
        step(0, 0, 0, 0, 0, 1, 2, 4'hF, 1);
        dbg_addr = 2'd2;
        #1;
        chk("coll_same", {4'd0, dbg_data}, 8'd8);
        issue(0, 2, 0, 1);
        step(0, 0, 0, 0, 0, 1, 3, 4'hF, 1);
        dbg_addr = 2'd3;
        #1;
        chk("coll_other", {4'd0, dbg_data}, 8'h0F);
        // reset mid-op
        issue(0, 2, 0, 1);
        reset();
        idle();
        chk("rst_done", {7'd0, done}, 8'd0);
        chk("rst_icount", icount, 8'd0);
        chk("rst_ready", {7'd0, in_ready}, 8'd1);
        // random traffic with occasional reset
        repeat (400)
            step($urandom_range(0, 1) == 1, 4'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                 $urandom_range(0, 2) == 0, 2'($urandom), 4'($urandom), $urandom_range(0, 60) != 0);
        // icount wrap
        reset();
        repeat (512) step(1, 4'($urandom_range(0, 15)), 2'($urandom), 2'($urandom), 2'($urandom), 0, 0, 0, 1);
        chk("wrap_icount", icount, 8'd0);
        load(3, 4'd7);
        issue(12, 3, 0, 1);
        idle();
        dbg_addr = 2'd3;
        #1;
        chk("op12_reg", {4'd0, dbg_data}, 8'd0);
        chk("op12_zero", {7'd0, zero}, 8'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
